// File: rtl/intr_sched.sv
// Nested priority-preemptive interrupt scheduler: edge-detects 4 request lines,
// grants the highest eligible source, redirects fetch and keeps an EPC stack.
module intr_sched #(
  parameter int N_SRC = 4,
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3C0,
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              intr_en_i,
  input  logic [N_SRC-1:0]  intr_mask_i,
  input  logic [N_SRC-1:0]  device_request_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  input  logic              eret_i,
  input  logic              stall_i,
  output logic              intr_jmp_o,
  output logic [ADDR_W-1:0] intr_jmp_addr_o,
  output logic              eret_jmp_o,
  output logic [ADDR_W-1:0] epc_out_o,
  output logic [N_SRC-1:0]  pending_o,
  output logic [N_SRC-1:0]  in_service_o,
  output logic [2:0]        depth_o
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  typedef enum logic [1:0] {IDLE, TAKE, RET} state_e;

  state_e              state_q;
  logic [N_SRC-1:0]    pending_q, pending_d, in_service_q, prev_req_q;
  logic [2:0]          depth_q;
  logic                eret_q, eret_d;
  logic                intr_jmp_q, eret_jmp_q;
  logic [ADDR_W-1:0]   intr_jmp_addr_q, epc_out_q;
  logic [ADDR_W-1:0]   stack_q [DEPTH];

  logic [N_SRC-1:0]    rise, allowed, elig, take_mask;
  logic [SRC_W-1:0]    win, top;
  logic                grant;
  logic [ADDR_W-1:0]   vec_addr;
  logic [PTR_W-1:0]    push_ptr, pop_ptr;

  always_comb begin
    rise = device_request_i & ~prev_req_q;
    // A source is allowed only if nothing at its own level or above is in service.
    allowed = '1;
    for (int i = 0; i < N_SRC; i++) begin
      for (int j = i; j < N_SRC; j++) begin
        if (in_service_q[j]) allowed[i] = 1'b0;
      end
    end
    elig = pending_q & intr_mask_i & allowed;
    win  = '0;
    top  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i]) win = SRC_W'(i);
      if (in_service_q[i]) top = SRC_W'(i);
    end
    grant = intr_en_i & (|elig) & (depth_q < DEPTH_L) & ~stall_i
          & (state_q == IDLE) & ~eret_q;
    take_mask = grant ? ({{(N_SRC-1){1'b0}}, 1'b1} << win) : '0;
    // A fresh rise on the bit being taken re-pends it.
    pending_d = (pending_q & ~take_mask) | rise;
    eret_d    = ((state_q == IDLE) ? 1'b0 : eret_q) | eret_i;
    vec_addr  = VEC_BASE + (ADDR_W'(win) << 2);
    push_ptr  = depth_q[PTR_W-1:0];
    pop_ptr   = push_ptr - {{(PTR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      in_service_q    <= '0;
      prev_req_q      <= '0;
      depth_q         <= '0;
      eret_q          <= 1'b0;
      intr_jmp_q      <= 1'b0;
      intr_jmp_addr_q <= '0;
      eret_jmp_q      <= 1'b0;
      epc_out_q       <= '0;
    end else begin
      prev_req_q <= device_request_i;
      pending_q  <= pending_d;
      eret_q     <= eret_d;
      case (state_q)
        IDLE: begin
          if (eret_q) begin
            if (depth_q != 3'd0) begin
              state_q           <= RET;
              eret_jmp_q        <= 1'b1;
              epc_out_q         <= stack_q[pop_ptr];
              in_service_q[top] <= 1'b0;
              depth_q           <= depth_q - 3'd1;
            end
          end else if (grant) begin
            state_q           <= TAKE;
            intr_jmp_q        <= 1'b1;
            intr_jmp_addr_q   <= vec_addr;
            in_service_q[win] <= 1'b1;
            depth_q           <= depth_q + 3'd1;
          end
        end
        TAKE: begin
          if (!stall_i) begin
            state_q         <= IDLE;
            intr_jmp_q      <= 1'b0;
            intr_jmp_addr_q <= '0;
          end
        end
        RET: begin
          if (!stall_i) begin
            state_q    <= IDLE;
            eret_jmp_q <= 1'b0;
            epc_out_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) stack_q[push_ptr] <= pc_next_i;
  end

  assign intr_jmp_o      = intr_jmp_q;
  assign intr_jmp_addr_o = intr_jmp_addr_q;
  assign eret_jmp_o      = eret_jmp_q;
  assign epc_out_o       = epc_out_q;
  assign pending_o       = pending_q;
  assign in_service_o    = in_service_q;
  assign depth_o         = depth_q;

endmodule

// File: tb/tb_intr_sched.sv
// Scoreboard bench for intr_sched: a queue/stack reference model predicts each
// redirect; a negedge monitor pops and compares whenever a redirect appears.
module tb_intr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       intr_en, eret, stall;
  logic [3:0] intr_mask, req;
  logic [9:0] pc_next;
  logic       intr_jmp, eret_jmp;
  logic [9:0] intr_jmp_addr, epc_out;
  logic [3:0] pending, in_service;
  logic [2:0] depth;

  always #5 clk = ~clk;

  intr_sched dut (
    .clk_i(clk), .rst_i(rst), .intr_en_i(intr_en), .intr_mask_i(intr_mask),
    .device_request_i(req), .pc_next_i(pc_next), .eret_i(eret), .stall_i(stall),
    .intr_jmp_o(intr_jmp), .intr_jmp_addr_o(intr_jmp_addr), .eret_jmp_o(eret_jmp),
    .epc_out_o(epc_out), .pending_o(pending), .in_service_o(in_service), .depth_o(depth)
  );

  typedef struct {
    bit         is_ret;
    logic [9:0] addr;
    logic [3:0] svc;
    logic [2:0] dep;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: set of pending ids, LIFO of active source ids and return PCs.
  logic [3:0] m_pend, m_prev, m_rise;
  int         m_svc[$];
  logic [9:0] m_epc[$];
  bit         m_eret, m_busy, m_served;
  int         m_top, m_w;
  ev_t        m_ev;

  function automatic logic [3:0] svc_mask();
    logic [3:0] m = '0;
    foreach (m_svc[i]) m[m_svc[i]] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_prev = '0; m_eret = 0; m_busy = 0;
      m_svc.delete(); m_epc.delete(); exp_q.delete();
    end else begin
      m_rise = req & ~m_prev;
      m_prev = req;
      m_served = 0;
      if (m_busy) begin
        if (!stall) m_busy = 0;
      end else if (m_eret) begin
        m_served = 1;
        if (m_svc.size() > 0) begin
          void'(m_svc.pop_back());
          m_ev.is_ret = 1;
          m_ev.addr   = m_epc.pop_back();
          m_ev.svc    = svc_mask();
          m_ev.dep    = 3'(m_svc.size());
          exp_q.push_back(m_ev);
          m_busy = 1;
        end
      end else begin
        m_top = -1;
        foreach (m_svc[i]) if (m_svc[i] > m_top) m_top = m_svc[i];
        m_w = -1;
        for (int i = 0; i < 4; i++)
          if (m_pend[i] && intr_mask[i] && i > m_top) m_w = i;
        if (intr_en && m_w >= 0 && m_svc.size() < 4 && !stall) begin
          m_svc.push_back(m_w);
          m_epc.push_back(pc_next);
          m_pend[m_w] = 1'b0;
          m_ev.is_ret = 0;
          m_ev.addr   = 10'(10'h3C0 + 4 * m_w);
          m_ev.svc    = svc_mask();
          m_ev.dep    = 3'(m_svc.size());
          exp_q.push_back(m_ev);
          m_busy = 1;
        end
      end
      m_pend = m_pend | m_rise;
      m_eret = m_served ? eret : (m_eret | eret);
    end
  end

  // Monitor
  bit         prev_act, act;
  logic [9:0] held_addr;
  ev_t        got;

  always @(negedge clk) begin
    if (rst) begin
      prev_act = 0;
    end else begin
      act = intr_jmp | eret_jmp;
      chk("jmp_exclusive", {31'd0, intr_jmp & eret_jmp}, 32'd0);
      chk("redirect_active", {31'd0, act}, {31'd0, m_busy});
      chk("pending", {28'd0, pending}, {28'd0, m_pend});
      if (act && !prev_act) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_redirect: got jmp=%0b eret_jmp=%0b, expected none at %0t",
                   intr_jmp, eret_jmp, $time);
        end else begin
          got = exp_q.pop_front();
          chk("redirect_kind", {31'd0, eret_jmp}, {31'd0, got.is_ret});
          held_addr = eret_jmp ? epc_out : intr_jmp_addr;
          chk(got.is_ret ? "epc_out" : "intr_jmp_addr", {22'd0, held_addr}, {22'd0, got.addr});
          chk("in_service", {28'd0, in_service}, {28'd0, got.svc});
          chk("depth", {29'd0, depth}, {29'd0, got.dep});
        end
      end else if (exp_q.size() > 0) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_redirect: got none, expected %s at %0t",
                 exp_q[0].is_ret ? "eret_jmp" : "intr_jmp", $time);
        exp_q.delete();
      end else if (act && prev_act) begin
        chk("held_addr", {22'd0, eret_jmp ? epc_out : intr_jmp_addr}, {22'd0, held_addr});
      end
      prev_act = act;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r; step(1); req = '0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; step(1); eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; intr_en = 0; intr_mask = '0; req = '0; pc_next = '0; eret = 0; stall = 0;
    step(2);
    chk("rst_intr_jmp", {31'd0, intr_jmp}, 32'd0);
    chk("rst_eret_jmp", {31'd0, eret_jmp}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_in_service", {28'd0, in_service}, 32'd0);
    chk("rst_depth", {29'd0, depth}, 32'd0);
    rst = 1'b0;

    // Single request on source 1
    intr_mask = 4'hF; intr_en = 1; pc_next = 10'h040;
    req = 4'b0010; step(1); req = '0;
    chk("single_pending", {28'd0, pending}, 32'h2);
    step(1);
    chk("single_jmp", {31'd0, intr_jmp}, 32'd1);
    chk("single_addr", {22'd0, intr_jmp_addr}, 32'h3C4);
    chk("single_depth", {29'd0, depth}, 32'd1);
    step(1);
    chk("single_jmp_drop", {31'd0, intr_jmp}, 32'd0);
    pulse_eret();
    step(1);
    chk("single_eret_jmp", {31'd0, eret_jmp}, 32'd1);
    chk("single_epc", {22'd0, epc_out}, 32'h040);
    chk("single_in_service", {28'd0, in_service}, 32'd0);
    step(3);

    // Simultaneous 0 and 2: 2 first, 0 blocked until ERET
    pc_next = 10'h100; pulse_req(4'b0101); step(6);
    pulse_eret(); step(8);
    pulse_eret(); step(6);

    // Nesting: src1 then src3 preempts
    pc_next = 10'h010; pulse_req(4'b0010); step(3);
    pc_next = 10'h055; pulse_req(4'b1000); step(4);
    pulse_eret(); step(4);
    pulse_eret(); step(5);

    // Stall before grant, then stall during TAKE
    stall = 1; pulse_req(4'b0100); step(4);
    stall = 0; step(1);
    stall = 1; step(4);
    stall = 0; step(3);
    stall = 1; pulse_eret(); step(4); stall = 0; step(3);

    // Masked / disabled, then spurious ERET
    intr_mask = '0; pulse_req(4'b1000); step(5);
    intr_en = 0; intr_mask = 4'hF; step(4);
    intr_en = 1; step(4);
    pulse_eret(); step(4);
    pulse_eret(); step(5);

    // Reset while redirecting; a held line re-pends after release
    pulse_req(4'b0010); step(1);
    chk("pre_rst_jmp", {31'd0, intr_jmp}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_jmp", {31'd0, intr_jmp}, 32'd0);
    chk("async_rst_depth", {29'd0, depth}, 32'd0);
    chk("async_rst_in_service", {28'd0, in_service}, 32'd0);
    req = 4'b0100;
    step(1); rst = 1'b0;
    step(2);
    chk("rerun_jmp", {31'd0, intr_jmp}, 32'd1);
    chk("rerun_addr", {22'd0, intr_jmp_addr}, 32'h3C8);
    req = '0; step(3);
    pulse_eret(); step(5);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      req       = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      stall     = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 9) == 0);
      intr_en   = ($urandom_range(0, 15) != 0);
      intr_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      pc_next   = 10'($urandom);
      step(1);
    end
    req = '0; eret = 0; stall = 0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
